// File: rtl/mod_reduce_3m_pkg.sv
// Shared residue-channel constants and helpers: default modulus, derived
// multiples of the modulus, and the stage-2 result selector encoding.
package mod_reduce_3m_pkg;

   localparam int unsigned RES_MODULUS   = 262139;
   localparam int unsigned RES_IN_WIDTH  = 20;
   localparam int unsigned RES_OUT_WIDTH = 18;

   localparam logic [RES_IN_WIDTH:0] M1 = (RES_IN_WIDTH + 1)'(RES_MODULUS);
   localparam logic [RES_IN_WIDTH:0] M2 = (RES_IN_WIDTH + 1)'(2 * RES_MODULUS);
   localparam logic [RES_IN_WIDTH:0] M3 = (RES_IN_WIDTH + 1)'(3 * RES_MODULUS);

   typedef enum logic [1:0] {
      SEL_D0,
      SEL_D1,
      SEL_D2,
      SEL_ERR
   } sel_e;

   // True when 3*modulus-1 fits the input sum and the modulus fits a residue.
   function automatic bit cfg_ok(input longint modulus, input int unsigned in_w,
                                 input int unsigned res_w);
      return (modulus >= 2) &&
             ((3 * modulus - 1) < (longint'(1) << in_w)) &&
             (modulus < (longint'(1) << res_w));
   endfunction

   localparam bit DEFAULT_CFG_OK = cfg_ok(longint'(RES_MODULUS), RES_IN_WIDTH, RES_OUT_WIDTH);

   function automatic sel_e pick_sel(input logic ge1, input logic ge2, input logic ge3);
      if (ge3)      return SEL_ERR;
      else if (ge2) return SEL_D2;
      else if (ge1) return SEL_D1;
      else          return SEL_D0;
   endfunction

endpackage

// File: rtl/mod_reduce_3m_if.sv
// Valid/ready bus between the 3-input adder, the reducer and the downstream channel.
interface mod_reduce_3m_if
   import mod_reduce_3m_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = RES_IN_WIDTH,
   parameter int unsigned RES_WIDTH = RES_OUT_WIDTH
);

   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_sum;
   logic                 out_valid;
   logic                 out_ready;
   logic [RES_WIDTH-1:0] out_res;
   logic                 out_err;
   logic                 err_sticky;

   modport master (
      output in_valid,
      output in_sum,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_res,
      input  out_err,
      input  err_sticky
   );

   modport slave (
      input  in_valid,
      input  in_sum,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_res,
      output out_err,
      output err_sticky
   );

endinterface

// File: rtl/mod_reduce_3m_pipe_ctl_2stage.sv
// Valid/advance control for a two-stage pipeline; empty stages always accept,
// so bubbles collapse while the output is stalled.
module pipe_ctl_2stage (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic adv1,
   output logic adv2,
   output logic s1_valid,
   output logic s2_valid
);

   always_comb begin
      adv2     = !s2_valid || out_ready;
      adv1     = !s1_valid || adv2;
      in_ready = adv1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (adv2) s2_valid <= s1_valid;
         if (adv1) s1_valid <= in_valid;
      end
   end

endmodule

// File: rtl/mod_reduce_3m.sv
// Two-stage reducer: stage 1 precomputes sum, sum-M, sum-2M and range flags;
// stage 2 selects the canonical residue or flags an out-of-range sum.
module mod_reduce_3m
   import mod_reduce_3m_pkg::*;
#(
   parameter int unsigned MODULUS   = RES_MODULUS,
   parameter int unsigned IN_WIDTH  = RES_IN_WIDTH,
   parameter int unsigned RES_WIDTH = RES_OUT_WIDTH
) (
   input logic           clk,
   input logic           reset,
   mod_reduce_3m_if.slave bus
);

   localparam logic [IN_WIDTH:0] K1 = (IN_WIDTH + 1)'(MODULUS);
   localparam logic [IN_WIDTH:0] K2 = (IN_WIDTH + 1)'(2 * MODULUS);
   localparam logic [IN_WIDTH:0] K3 = (IN_WIDTH + 1)'(3 * MODULUS);

   if (!cfg_ok(longint'(MODULUS), IN_WIDTH, RES_WIDTH)) begin : g_cfg_bad
      $error("mod_reduce_3m: MODULUS does not fit IN_WIDTH/RES_WIDTH");
   end

   logic adv1, adv2, s1_valid, s2_valid;

   pipe_ctl_2stage u_ctl (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (bus.in_valid),
      .out_ready (bus.out_ready),
      .in_ready  (bus.in_ready),
      .adv1      (adv1),
      .adv2      (adv2),
      .s1_valid  (s1_valid),
      .s2_valid  (s2_valid)
   );

   logic [IN_WIDTH:0] sum_ext, sub1, sub2;
   logic              ge1, ge2, ge3;

   always_comb begin
      sum_ext = {1'b0, bus.in_sum};
      sub1    = sum_ext - K1;
      sub2    = sum_ext - K2;
      ge1     = sum_ext >= K1;
      ge2     = sum_ext >= K2;
      ge3     = sum_ext >= K3;
   end

   logic [IN_WIDTH-1:0] d0_q;
   logic [IN_WIDTH:0]   d1_q, d2_q;
   logic                ge1_q, ge2_q, ge3_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         d0_q  <= '0;
         d1_q  <= '0;
         d2_q  <= '0;
         ge1_q <= 1'b0;
         ge2_q <= 1'b0;
         ge3_q <= 1'b0;
      end else if (adv1) begin
         d0_q  <= bus.in_sum;
         d1_q  <= sub1;
         d2_q  <= sub2;
         ge1_q <= ge1;
         ge2_q <= ge2;
         ge3_q <= ge3;
      end
   end

   // Upper bits are zero whenever the corresponding candidate is selected.
   logic unused_hi;
   assign unused_hi = ^{d0_q[IN_WIDTH-1:RES_WIDTH], d1_q[IN_WIDTH:RES_WIDTH],
                        d2_q[IN_WIDTH:RES_WIDTH]};

   sel_e                 sel;
   logic [RES_WIDTH-1:0] res_nxt;
   logic                 err_nxt;

   always_comb begin
      sel     = pick_sel(ge1_q, ge2_q, ge3_q);
      res_nxt = '0;
      err_nxt = 1'b0;
      unique case (sel)
         SEL_ERR: err_nxt = 1'b1;
         SEL_D2:  res_nxt = d2_q[RES_WIDTH-1:0];
         SEL_D1:  res_nxt = d1_q[RES_WIDTH-1:0];
         SEL_D0:  res_nxt = d0_q[RES_WIDTH-1:0];
         default: res_nxt = '0;
      endcase
   end

   logic [RES_WIDTH-1:0] res_q;
   logic                 err_q, sticky_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q    <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         if (adv2) begin
            res_q <= res_nxt;
            err_q <= err_nxt;
         end
         if (s2_valid && bus.out_ready && err_q) sticky_q <= 1'b1;
      end
   end

   always_comb begin
      bus.out_valid  = s2_valid;
      bus.out_res    = res_q;
      bus.out_err    = err_q;
      bus.err_sticky = sticky_q;
   end

endmodule

// File: tb/tb_mod_reduce_3m.sv
// Bench for mod_reduce_3m: queue-based reference model checked every cycle,
// plus directed cases with literal expected residues and latencies.
module tb_mod_reduce_3m;

   localparam int unsigned M  = 262139;
   localparam int unsigned IW = 20;
   localparam int unsigned RW = 18;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mod_reduce_3m_if #(.IN_WIDTH(IW), .RES_WIDTH(RW)) bus ();

   mod_reduce_3m #(.MODULUS(M), .IN_WIDTH(IW), .RES_WIDTH(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int unsigned res;
      bit          err;
   } exp_t;

   function automatic exp_t model(input int unsigned s);
      exp_t r;
      if (s >= 3 * M) begin
         r.res = 0;
         r.err = 1'b1;
      end else begin
         r.res = s % M;
         r.err = 1'b0;
      end
      return r;
   endfunction

   exp_t        q[$];
   bit          sticky_m   = 1'b0;
   bit          stall_prev = 1'b0;
   int unsigned held_res   = 0;
   bit          held_err   = 1'b0;
   int          n_in       = 0;
   int          n_out      = 0;

   // Inputs change #1 after posedge, so negedge sees the values the next edge samples.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         sticky_m   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         chk("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
         chk("err_sticky", bus.err_sticky, sticky_m);
         if (q.size() == 0) chk("idle_out_valid", bus.out_valid, 0);
         if (stall_prev) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_res", bus.out_res, held_res);
            chk("hold_err", bus.out_err, held_err);
         end
         if (bus.out_valid && q.size() > 0) begin
            chk("out_res", bus.out_res, q[0].res);
            chk("out_err", bus.out_err, q[0].err);
         end
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            if (q[0].err) sticky_m = 1'b1;
            void'(q.pop_front());
            n_out++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(int'(bus.in_sum)));
            n_in++;
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held_res   = bus.out_res;
         held_err   = bus.out_err;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pipeline must be empty on entry; checks 2-cycle latency with literal results.
   task automatic single(input int unsigned v, input int unsigned exp_res, input bit exp_err,
                         input string name);
      tick();
      bus.in_valid  = 1'b1;
      bus.in_sum    = IW'(v);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk({name, "_accept"}, bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_lat1_valid"}, bus.out_valid, 0);
      @(negedge clk);
      chk({name, "_lat2_valid"}, bus.out_valid, 1);
      chk({name, "_res"}, bus.out_res, exp_res);
      chk({name, "_err"}, bus.out_err, exp_err);
   endtask

   task automatic drain();
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int out0;
      int in0;
      int cyc;
      int idx;
      bus.in_valid  = 1'b0;
      bus.in_sum    = '0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_res", bus.out_res, 0);
      chk("rst_out_err", bus.out_err, 0);
      chk("rst_sticky", bus.err_sticky, 0);
      chk("rst_in_ready", bus.in_ready, 1);

      // Model pins against hand-computed residues.
      chk("model_2m", model(524278).res, 0);
      chk("model_3m1", model(786416).res, 262138);
      chk("model_3m", model(786417).err, 1);

      single(0, 0, 0, "s0");
      single(262138, 262138, 0, "m_minus1");
      single(262139, 0, 0, "m");
      single(524278, 0, 0, "two_m");
      single(786416, 262138, 0, "three_m_minus1");
      chk("no_sticky_yet", bus.err_sticky, 0);

      single(786417, 0, 1, "three_m");
      @(negedge clk);
      chk("sticky_set", bus.err_sticky, 1);
      single(1048575, 0, 1, "max_in");
      repeat (3) @(negedge clk);
      chk("sticky_held", bus.err_sticky, 1);
      drain();

      // Backpressure: 10 sequential values, out_ready low for 5 cycles mid-stream.
      out0 = n_out;
      idx  = 0;
      cyc  = 0;
      while (idx < 10 && cyc < 40) begin
         tick();
         bus.out_ready = !(cyc >= 3 && cyc < 8);
         bus.in_valid  = 1'b1;
         bus.in_sum    = IW'(262130 + idx);
         @(negedge clk);
         if (cyc == 5) chk("bp_in_ready_low", bus.in_ready, 0);
         if (bus.in_ready) idx++;
         cyc++;
      end
      chk("bp_all_accepted", idx, 10);
      drain();
      chk("bp_out_count", n_out - out0, 10);

      // Bubble collapse: s2 stalled, s1 empty, new item still accepted.
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sum    = IW'(5);
      @(negedge clk);
      chk("bub_first_accept", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      bus.in_sum   = IW'(6);
      @(negedge clk);
      chk("bub_accept_s1", bus.in_ready, 1);
      chk("bub_s2_res", bus.out_res, 5);
      tick();
      bus.in_sum = IW'(7);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bub_in_ready_low", bus.in_ready, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bub_in_ready_rise", bus.in_ready, 1);
      drain();

      // Reset with both stages full.
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sum    = IW'(11);
      tick();
      bus.in_sum = IW'(12);
      tick();
      bus.in_sum = IW'(13);
      @(negedge clk);
      chk("full_in_ready", bus.in_ready, 0);
      tick();
      reset = 1'b1;
      tick();
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("postrst_out_valid", bus.out_valid, 0);
      chk("postrst_in_ready", bus.in_ready, 1);
      chk("postrst_sticky", bus.err_sticky, 0);
      single(262140, 1, 0, "postrst");
      drain();

      // Random traffic against the model.
      in0 = n_in;
      cyc = 0;
      while (n_in - in0 < 10000 && cyc < 60000) begin
         tick();
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = $urandom_range(0, 1) != 0;
         case ($urandom_range(0, 15))
            0:       bus.in_sum = IW'($urandom_range(3 * M, (1 << IW) - 1));
            1:       bus.in_sum = IW'(M * $urandom_range(0, 3) - $urandom_range(0, 1));
            default: bus.in_sum = IW'($urandom_range(0, 3 * M - 1));
         endcase
         cyc++;
      end
      @(negedge clk);
      chk("random_items", (n_in - in0 >= 10000) ? 1 : 0, 1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
